// File: rtl/edge_event_scheduler_if.sv
// Event hand-off port between edge_event_scheduler (master) and its consumer (slave).
// A transfer happens on an enabled clk edge where event_valid_o && event_ready_i.
// While valid is high and ready is low, chan/rising hold. Ready may depend on valid.
interface edge_event_scheduler_if #(
  parameter int IDX_W = 2
);
  logic             event_valid_o;
  logic             event_ready_i;
  logic [IDX_W-1:0] event_chan_o;
  logic             event_rising_o;

  modport master (
    output event_valid_o,
    output event_chan_o,
    output event_rising_o,
    input  event_ready_i
  );

  modport slave (
    input  event_valid_o,
    input  event_chan_o,
    input  event_rising_o,
    output event_ready_i
  );
endinterface

// File: rtl/edge_event_scheduler.sv
// Per-channel edge detection with one pending slot per channel, round-robin arbitration
// into a single registered output slot. rr_ptr_o exposes the arbiter pointer for status.
module edge_event_scheduler #(
  parameter int CHANNELS = 4,
  parameter int IDX_W    = $clog2(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  clk_en,
  input  logic [CHANNELS-1:0]   sense_i,
  input  logic [CHANNELS-1:0]   chan_en_i,
  input  logic [2*CHANNELS-1:0] edge_sel_i,
  edge_event_scheduler_if.master evt,
  output logic [CHANNELS-1:0]   pending_o,
  output logic [CHANNELS-1:0]   overflow_o,
  input  logic                  overflow_clr_i,
  output logic [IDX_W-1:0]      rr_ptr_o
);

  logic [CHANNELS-1:0] prev_q, pend_v_q, pend_r_q, ovf_q;
  logic [CHANNELS-1:0] pend_v_d, pend_r_d, ovf_d;
  logic [CHANNELS-1:0] rise, fall, qual, gnt_oh;
  logic                valid_q, rising_q;
  logic [IDX_W-1:0]    chan_q, rr_q;

  logic                slot_free, any_pend, hi_vld, do_grant;
  logic [IDX_W-1:0]    hi_idx, lo_idx, grant_idx, rr_next;

  always_comb begin
    rise = '0;
    fall = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      rise[c] = ~prev_q[c] &  sense_i[c] & chan_en_i[c] & edge_sel_i[2*c];
      fall[c] =  prev_q[c] & ~sense_i[c] & chan_en_i[c] & edge_sel_i[2*c+1];
    end
    qual = rise | fall;
  end

  assign slot_free = ~valid_q | evt.event_ready_i;

  // Two-pass priority search: first indices at or above rr_q, then wrap to the bottom.
  always_comb begin
    hi_vld   = 1'b0;
    hi_idx   = '0;
    any_pend = 1'b0;
    lo_idx   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!hi_vld && pend_v_q[i] && (IDX_W'(i) >= rr_q)) begin
        hi_vld = 1'b1;
        hi_idx = IDX_W'(i);
      end
      if (!any_pend && pend_v_q[i]) begin
        any_pend = 1'b1;
        lo_idx   = IDX_W'(i);
      end
    end
    grant_idx = hi_vld ? hi_idx : lo_idx;
    do_grant  = slot_free & any_pend;
    rr_next   = (grant_idx == IDX_W'(CHANNELS-1)) ? '0 : grant_idx + 1'b1;
  end

  always_comb begin
    gnt_oh   = '0;
    pend_v_d = pend_v_q;
    pend_r_d = pend_r_q;
    ovf_d    = overflow_clr_i ? '0 : ovf_q;
    for (int c = 0; c < CHANNELS; c++) begin
      gnt_oh[c] = do_grant && (grant_idx == IDX_W'(c));
      if (!chan_en_i[c]) begin
        pend_v_d[c] = 1'b0;
      end else if (qual[c]) begin
        // A granted entry frees its slot this cycle, so the new edge replaces it cleanly.
        if (pend_v_q[c] && !gnt_oh[c]) begin
          ovf_d[c] = 1'b1;
        end else begin
          pend_v_d[c] = 1'b1;
          pend_r_d[c] = rise[c];
        end
      end else if (gnt_oh[c]) begin
        pend_v_d[c] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      prev_q   <= '0;
      pend_v_q <= '0;
      pend_r_q <= '0;
      ovf_q    <= '0;
      valid_q  <= 1'b0;
      chan_q   <= '0;
      rising_q <= 1'b0;
      rr_q     <= '0;
    end else if (clk_en) begin
      prev_q   <= sense_i & chan_en_i;
      pend_v_q <= pend_v_d;
      pend_r_q <= pend_r_d;
      ovf_q    <= ovf_d;
      if (slot_free) begin
        valid_q <= any_pend;
        if (any_pend) begin
          chan_q   <= grant_idx;
          rising_q <= pend_r_q[grant_idx];
          rr_q     <= rr_next;
        end
      end
    end
  end

  assign evt.event_valid_o  = valid_q;
  assign evt.event_chan_o   = chan_q;
  assign evt.event_rising_o = rising_q;
  assign pending_o          = pend_v_q;
  assign overflow_o         = ovf_q;
  assign rr_ptr_o           = rr_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Bench for edge_event_scheduler: directed table, hand-written corner sequences, and
// randomized traffic checked against a per-cycle behavioural model plus a transfer queue.
module tb_edge_event_scheduler;
  localparam int CH = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            async_rst_n = 1'b0;
  logic            clk_en = 1'b1;
  logic [CH-1:0]   sense = '0;
  logic [CH-1:0]   chan_en = '0;
  logic [2*CH-1:0] edge_sel = '0;
  logic            ovf_clr = 1'b0;
  logic [CH-1:0]   pending, overflow;
  logic [IW-1:0]   rr_ptr;

  edge_event_scheduler_if #(.IDX_W(IW)) evt ();

  edge_event_scheduler #(.CHANNELS(CH)) dut (
    .clk            (clk),
    .async_rst_n    (async_rst_n),
    .clk_en         (clk_en),
    .sense_i        (sense),
    .chan_en_i      (chan_en),
    .edge_sel_i     (edge_sel),
    .evt            (evt),
    .pending_o      (pending),
    .overflow_o     (overflow),
    .overflow_clr_i (ovf_clr),
    .rr_ptr_o       (rr_ptr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_mis = 0;
  logic [IW:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [CH-1:0] m_prev, m_pv, m_pr, m_ovf;
  bit          m_valid, m_rising;
  int          m_chan, m_rr;

  task automatic model_reset();
    m_prev = '0; m_pv = '0; m_pr = '0; m_ovf = '0;
    m_valid = 1'b0; m_rising = 1'b0; m_chan = 0; m_rr = 0;
  endtask

  task automatic model_step();
    bit free, r, f;
    int g, c;
    bit [CH-1:0] pv_n, pr_n, ov_n;
    free = !m_valid || evt.event_ready_i;
    g = -1;
    if (free)
      for (int k = 0; k < CH; k++) begin
        c = (m_rr + k) % CH;
        if (g < 0 && m_pv[c]) g = c;
      end
    pv_n = m_pv;
    pr_n = m_pr;
    ov_n = ovf_clr ? '0 : m_ovf;
    for (int ch = 0; ch < CH; ch++) begin
      r = chan_en[ch] && sense[ch] && !m_prev[ch] && edge_sel[2*ch];
      f = chan_en[ch] && !sense[ch] && m_prev[ch] && edge_sel[2*ch+1];
      if (!chan_en[ch]) pv_n[ch] = 1'b0;
      else if (r || f) begin
        if (m_pv[ch] && g != ch) ov_n[ch] = 1'b1;
        else begin pv_n[ch] = 1'b1; pr_n[ch] = r; end
      end else if (g == ch) pv_n[ch] = 1'b0;
    end
    if (free) begin
      if (g >= 0) begin
        m_valid = 1'b1; m_chan = g; m_rising = m_pr[g]; m_rr = (g + 1) % CH;
      end else m_valid = 1'b0;
    end
    m_prev = sense & chan_en;
    m_pv = pv_n; m_pr = pr_n; m_ovf = ov_n;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [IW:0] e;
    if (clk_en) begin
      if (m_valid && evt.event_ready_i) exp_q.push_back({IW'(m_chan), m_rising});
      if (evt.event_valid_o && evt.event_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_mis++;
          $display("FAIL xfer_unexpected: got chan %0d rising %0b expected no transfer at %0t",
                   evt.event_chan_o, evt.event_rising_o, $time);
        end else begin
          e = exp_q.pop_front();
          check("xfer_event", {evt.event_chan_o, evt.event_rising_o}, e);
        end
      end
      model_step();
    end
    @(posedge clk);
    #1;
    check("valid", evt.event_valid_o, m_valid);
    if (m_valid) begin
      check("chan", evt.event_chan_o, m_chan);
      check("rising", evt.event_rising_o, m_rising);
    end
    check("pending", pending, m_pv);
    check("overflow", overflow, m_ovf);
    check("rr_ptr", rr_ptr, m_rr);
  endtask

  task automatic do_reset();
    async_rst_n = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_rst_n = 1'b1;
  endtask

  task automatic set_in(input logic [CH-1:0] s, input logic [CH-1:0] en,
                        input logic [2*CH-1:0] sel, input logic rdy);
    sense = s; chan_en = en; edge_sel = sel; evt.event_ready_i = rdy;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [CH-1:0]   sense;
    logic [CH-1:0]   en;
    logic [2*CH-1:0] sel;
    logic            rdy;
    logic            vld;
    logic [IW-1:0]   chan;
    logic            rise;
    logic [CH-1:0]   pend;
    logic [IW-1:0]   rr;
  } vec_t;

  vec_t tbl[19];

  initial begin
    // round-robin on simultaneous rises, then falls; then a single rising edge on ch2
    tbl[0]  = '{4'h0, 4'hF, 8'hFF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 2'd0};
    tbl[1]  = '{4'hF, 4'hF, 8'hFF, 1'b1, 1'b0, 2'd0, 1'b0, 4'hF, 2'd0};
    tbl[2]  = '{4'hF, 4'hF, 8'hFF, 1'b1, 1'b1, 2'd0, 1'b1, 4'hE, 2'd1};
    tbl[3]  = '{4'hF, 4'hF, 8'hFF, 1'b1, 1'b1, 2'd1, 1'b1, 4'hC, 2'd2};
    tbl[4]  = '{4'hF, 4'hF, 8'hFF, 1'b1, 1'b1, 2'd2, 1'b1, 4'h8, 2'd3};
    tbl[5]  = '{4'hF, 4'hF, 8'hFF, 1'b1, 1'b1, 2'd3, 1'b1, 4'h0, 2'd0};
    tbl[6]  = '{4'hF, 4'hF, 8'hFF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 2'd0};
    tbl[7]  = '{4'h0, 4'hF, 8'hFF, 1'b1, 1'b0, 2'd0, 1'b0, 4'hF, 2'd0};
    tbl[8]  = '{4'h0, 4'hF, 8'hFF, 1'b1, 1'b1, 2'd0, 1'b0, 4'hE, 2'd1};
    tbl[9]  = '{4'h0, 4'hF, 8'hFF, 1'b1, 1'b1, 2'd1, 1'b0, 4'hC, 2'd2};
    tbl[10] = '{4'h0, 4'hF, 8'hFF, 1'b1, 1'b1, 2'd2, 1'b0, 4'h8, 2'd3};
    tbl[11] = '{4'h0, 4'hF, 8'hFF, 1'b1, 1'b1, 2'd3, 1'b0, 4'h0, 2'd0};
    tbl[12] = '{4'h0, 4'hF, 8'hFF, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 2'd0};
    tbl[13] = '{4'h0, 4'h4, 8'h10, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 2'd0};
    tbl[14] = '{4'h4, 4'h4, 8'h10, 1'b1, 1'b0, 2'd0, 1'b0, 4'h4, 2'd0};
    tbl[15] = '{4'h4, 4'h4, 8'h10, 1'b1, 1'b1, 2'd2, 1'b1, 4'h0, 2'd3};
    tbl[16] = '{4'h4, 4'h4, 8'h10, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 2'd3};
    tbl[17] = '{4'h0, 4'h4, 8'h10, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 2'd3};
    tbl[18] = '{4'h0, 4'h4, 8'h10, 1'b1, 1'b0, 2'd0, 1'b0, 4'h0, 2'd3};
  end

  // ---------------- test sequence ----------------
  initial begin
    evt.event_ready_i = 1'b0;
    model_reset();
    do_reset();
    check("rst_valid", evt.event_valid_o, 0);
    check("rst_chan", evt.event_chan_o, 0);
    check("rst_rising", evt.event_rising_o, 0);
    check("rst_pending", pending, 0);
    check("rst_overflow", overflow, 0);
    check("rst_rr", rr_ptr, 0);

    for (int i = 0; i < 19; i++) begin
      set_in(tbl[i].sense, tbl[i].en, tbl[i].sel, tbl[i].rdy);
      tick();
      check("tbl_valid", evt.event_valid_o, tbl[i].vld);
      if (tbl[i].vld) begin
        check("tbl_chan", evt.event_chan_o, tbl[i].chan);
        check("tbl_rising", evt.event_rising_o, tbl[i].rise);
      end
      check("tbl_pending", pending, tbl[i].pend);
      check("tbl_overflow", overflow, 0);
      check("tbl_rr", rr_ptr, tbl[i].rr);
    end

    // backpressure: ch1 held while ch3 waits
    do_reset();
    set_in(4'h0, 4'hA, 8'h44, 1'b0); tick();
    sense = 4'hA; tick();
    check("bp_pending_both", pending, 4'hA);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", evt.event_valid_o, 1);
      check("bp_chan_hold", evt.event_chan_o, 1);
      check("bp_rising_hold", evt.event_rising_o, 1);
      check("bp_ch3_pending", pending, 4'h8);
    end
    evt.event_ready_i = 1'b1; tick();
    check("bp_next_chan", evt.event_chan_o, 3);
    check("bp_next_valid", evt.event_valid_o, 1);
    tick();
    check("bp_drained", evt.event_valid_o, 0);

    // overflow: slot busy with ch1, ch0 rises then falls
    do_reset();
    set_in(4'h0, 4'h3, 8'h07, 1'b0); tick();
    sense = 4'h2; tick();
    tick();
    check("ovf_slot_ch1", evt.event_chan_o, 1);
    sense = 4'h3; tick();
    sense = 4'h2; tick();
    check("ovf_set", overflow, 4'h1);
    check("ovf_pend_kept", pending, 4'h1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 4'h0);
    evt.event_ready_i = 1'b1; tick();
    check("ovf_kept_chan", evt.event_chan_o, 0);
    check("ovf_kept_rising", evt.event_rising_o, 1);
    tick();

    // enable while high, then clk_en gating with valid && ready
    do_reset();
    set_in(4'h8, 4'h0, 8'h40, 1'b1); tick();
    check("en_off_quiet", pending, 4'h0);
    chan_en = 4'h8; tick();
    tick();
    check("en_rise_valid", evt.event_valid_o, 1);
    check("en_rise_chan", evt.event_chan_o, 3);
    check("en_rise_rising", evt.event_rising_o, 1);
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sense = (i < 2) ? 4'h0 : 4'h8;
      tick();
      check("gate_valid", evt.event_valid_o, 1);
      check("gate_chan", evt.event_chan_o, 3);
      check("gate_rr", rr_ptr, 0);
    end
    clk_en = 1'b1; tick();
    check("gate_release", evt.event_valid_o, 0);
    check("gate_no_edge", pending, 4'h0);

    // asynchronous reset mid-stream
    set_in(4'h0, 4'hF, 8'hFF, 1'b0); tick();
    sense = 4'hF; tick(); tick();
    sense = 4'h0; tick();
    #3;
    async_rst_n = 1'b0;
    #1;
    check("arst_valid", evt.event_valid_o, 0);
    check("arst_chan", evt.event_chan_o, 0);
    check("arst_rising", evt.event_rising_o, 0);
    check("arst_pending", pending, 0);
    check("arst_overflow", overflow, 0);
    check("arst_rr", rr_ptr, 0);
    do_reset();

    // randomized traffic against the model
    edge_sel = 8'hFF;
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      sense = CH'($urandom);
      chan_en = ($urandom_range(0, 7) == 0) ? CH'($urandom) : 4'hF;
      if ($urandom_range(0, 15) == 0) edge_sel = (2*CH)'($urandom);
      evt.event_ready_i = ($urandom_range(0, 99) < ((i / 100) % 2 ? 30 : 85));
      clk_en = ($urandom_range(0, 4) != 0);
      ovf_clr = ($urandom_range(0, 19) == 0);
      tick();
    end
    clk_en = 1'b1;
    ovf_clr = 1'b0;
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
